// File: rtl/mem_access_stage.sv
// Memory-access / writeback stage: one instruction per handshake, single-outstanding
// data-memory bus with wait-state timeout, registered one-cycle writeback pulse.
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        store,
    input  logic        load,
    input  logic        we_reg,
    input  logic [2:0]  funct3,
    input  logic [31:0] ls_mem_addr,
    input  logic [31:0] wd_mem,
    input  logic [31:0] wd_reg,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WAIT);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [4:0]      r_rd;

    logic            w_accept;
    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_illegal;
    logic            w_fault;
    logic [CW-1:0]   w_cnt_inc;
    logic [31:0]     w_st_wdata;
    logic [3:0]      w_st_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_data;

    assign in_ready  = (r_state == S_IDLE) && !RST;
    assign w_accept  = in_valid && in_ready;
    assign w_is_mem  = load || store;
    assign w_cnt_inc = r_wait_cnt + CW'(1);

    // Load takes priority when both flags are set, so legality follows the load table.
    assign w_misaligned = ((funct3[1:0] == 2'b01) && ls_mem_addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (ls_mem_addr[1:0] != 2'b00));
    assign w_illegal    = load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                               : (funct3[2] || (funct3[1:0] == 2'b11));
    assign w_fault      = w_misaligned || w_illegal;

    always_comb begin
        w_st_wdata = wd_mem;
        w_st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{wd_mem[7:0]}};
                w_st_wstrb = 4'b0001 << ls_mem_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{wd_mem[15:0]}};
                w_st_wstrb = 4'b0011 << ls_mem_addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0: w_byte = dmem_rdata[7:0];
            2'd1: w_byte = dmem_rdata[15:8];
            2'd2: w_byte = dmem_rdata[23:16];
            2'd3: w_byte = dmem_rdata[31:24];
            default: ;
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_is_load  <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            r_rd       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_wstrb <= 4'h0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0;
            wb_err     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        wb_rd <= rd_in;
                        if (!w_is_mem) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b0;
                            wb_we    <= we_reg && (rd_in != 5'd0);
                            wb_data  <= wd_reg;
                        end else if (w_fault) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= 32'h0;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_wait_cnt <= '0;
                            r_is_load  <= load;
                            r_funct3   <= funct3;
                            r_addr_lo  <= ls_mem_addr[1:0];
                            r_rd       <= rd_in;
                            dmem_req   <= 1'b1;
                            dmem_we    <= !load;
                            dmem_addr  <= {ls_mem_addr[31:2], 2'b00};
                            dmem_wdata <= load ? 32'h0 : w_st_wdata;
                            dmem_wstrb <= load ? 4'h0 : w_st_wstrb;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack on the final wait cycle beats the timeout.
                    if (dmem_ack) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                        dmem_req   <= 1'b0;
                        wb_valid   <= 1'b1;
                        wb_err     <= 1'b0;
                        wb_rd      <= r_rd;
                        wb_we      <= r_is_load && (r_rd != 5'd0);
                        wb_data    <= r_is_load ? w_load_data : 32'h0;
                    end else if (w_cnt_inc == W_MAX) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                        dmem_req   <= 1'b0;
                        wb_valid   <= 1'b1;
                        wb_err     <= 1'b1;
                        wb_rd      <= r_rd;
                        wb_we      <= 1'b0;
                        wb_data    <= 32'h0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset/back-to-back
// sequences and randomized instructions checked against a behavioural model.
module tb_mem_access_stage;
    localparam int MAXW = 4;

    typedef struct packed {
        logic        bus;
        logic        err;
        logic        we;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        we_reg;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd_mem;
        logic [31:0] wd_reg;
        logic [4:0]  rd;
        int          dly;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        store = 1'b0;
    logic        load = 1'b0;
    logic        we_reg = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ls_mem_addr = 32'h0;
    logic [31:0] wd_mem = 32'h0;
    logic [31:0] wd_reg = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    int n_cmp = 0;
    int n_fail = 0;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .CLK(clk), .RST(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .store(store), .load(load), .we_reg(we_reg), .funct3(funct3),
        .ls_mem_addr(ls_mem_addr), .wd_mem(wd_mem), .wd_reg(wd_reg), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference model: access size, legality and lane placement from plain arithmetic.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          nbytes;
        int          off;
        logic        legal;
        longint      mask;
        logic [31:0] val;
        e = '0;
        if (!v.load && !v.store) begin
            e.we   = v.we_reg && (v.rd != 5'd0);
            e.data = v.wd_reg;
            return e;
        end
        if (v.load) legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else        legal = v.f3 inside {3'd0, 3'd1, 3'd2};
        nbytes = 1 << v.f3[1:0];
        off    = int'(v.addr % 4);
        if (!legal || (off % nbytes) != 0) begin
            e.err = 1'b1;
            return e;
        end
        e.bus = 1'b1;
        if (!v.load) begin
            for (int k = 0; k < 4; k++) begin
                e.wstrb[k] = (k >= off) && (k < off + nbytes);
                e.wdata[8*k +: 8] = v.wd_mem[8*(k % nbytes) +: 8];
            end
        end
        if (v.dly < 1 || v.dly > MAXW) begin
            e.err = 1'b1;
            return e;
        end
        if (v.load) begin
            mask = (longint'(1) << (8 * nbytes)) - 1;
            val  = 32'((longint'(v.rdata) >> (8 * off)) & mask);
            if (!v.f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~32'(mask);
            e.we   = (v.rd != 5'd0);
            e.data = val;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic ld, input logic st, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdm, input logic [31:0] wdr,
                                input logic [4:0] rd, input int dly, input logic [31:0] rdat,
                                input logic bus, input logic err, input logic ewe,
                                input logic [31:0] edata, input logic [3:0] strb, input logic [31:0] ewdata);
        vec_t v;
        v.load = ld; v.store = st; v.we_reg = we; v.f3 = f3; v.addr = addr;
        v.wd_mem = wdm; v.wd_reg = wdr; v.rd = rd; v.dly = dly; v.rdata = rdat;
        v.e.bus = bus; v.e.err = err; v.e.we = ewe; v.e.data = edata;
        v.e.wstrb = strb; v.e.wdata = ewdata;
        return v;
    endfunction

    task automatic run_instr(input vec_t v, input int id);
        int n_acc;
        @(negedge clk);
        chk1("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; load = v.load; store = v.store; we_reg = v.we_reg;
        funct3 = v.f3; ls_mem_addr = v.addr; wd_mem = v.wd_mem; wd_reg = v.wd_reg; rd_in = v.rd;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'b0;
        if (!v.e.bus) begin
            chk1("direct_req_low", dmem_req, 1'b0);
        end else begin
            chk1("req_rise", dmem_req, 1'b1);
            chk1("req_we", dmem_we, v.store && !v.load);
            chk32("req_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk32("req_wstrb", 32'(dmem_wstrb), 32'(v.e.wstrb));
            if (v.store && !v.load) chk32("req_wdata", dmem_wdata, v.e.wdata);
            chk1("no_early_wb", wb_valid, 1'b0);
            n_acc = (v.dly >= 1 && v.dly <= MAXW) ? v.dly : MAXW;
            for (int c = 1; c <= n_acc; c++) begin
                @(negedge clk);
                if (c == v.dly) begin
                    dmem_ack = 1'b1; dmem_rdata = v.rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (c < n_acc) begin
                    chk1("access_wb_quiet", wb_valid, 1'b0);
                    chk1("access_req_held", dmem_req, 1'b1);
                    chk32("access_wstrb_held", 32'(dmem_wstrb), 32'(v.e.wstrb));
                end
            end
            chk1("req_dropped", dmem_req, 1'b0);
        end
        chk1("wb_valid", wb_valid, 1'b1);
        chk1("wb_err", wb_err, v.e.err);
        chk1("wb_we", wb_we, v.e.we);
        if (!(v.e.err && v.e.bus)) chk32("wb_data", wb_data, v.e.data);
        if (!v.e.err) chk32("wb_rd", 32'(wb_rd), 32'(v.rd));
        $display("txn %0d: ld=%b st=%b f3=%0d addr=0x%08h dly=%0d -> wb_err=%b wb_we=%b wb_data=0x%08h",
                 id, v.load, v.store, v.f3, v.addr, v.dly, wb_err, wb_we, wb_data);
    endtask

    vec_t tbl[18];
    vec_t rv;

    initial begin
        tbl[0]  = mk(0,0,1,3'd0,32'h0,  32'h0,       32'h1234,5'd5, 1,32'h0,       0,0,1,32'h1234,    4'h0,32'h0);
        tbl[1]  = mk(0,1,0,3'd0,32'h103,32'hAB,      32'h0,   5'd2, 3,32'h0,       1,0,0,32'h0,       4'h8,32'hABABABAB);
        tbl[2]  = mk(1,0,1,3'd0,32'h102,32'h0,       32'h0,   5'd7, 1,32'h80F01234,1,0,1,32'hFFFFFFF0,4'h0,32'h0);
        tbl[3]  = mk(1,0,1,3'd4,32'h102,32'h0,       32'h0,   5'd8, 2,32'h80F01234,1,0,1,32'h000000F0,4'h0,32'h0);
        tbl[4]  = mk(1,0,1,3'd1,32'h102,32'h0,       32'h0,   5'd9, 1,32'h80F01234,1,0,1,32'hFFFF80F0,4'h0,32'h0);
        tbl[5]  = mk(1,0,1,3'd2,32'h002,32'h0,       32'h0,   5'd10,1,32'h0,       0,1,0,32'h0,       4'h0,32'h0);
        tbl[6]  = mk(1,0,1,3'd1,32'h102,32'h0,       32'h0,   5'd0, 2,32'h80F01234,1,0,0,32'hFFFF80F0,4'h0,32'h0);
        tbl[7]  = mk(1,0,1,3'd2,32'h200,32'h0,       32'h0,   5'd3, 5,32'h0,       1,1,0,32'h0,       4'h0,32'h0);
        tbl[8]  = mk(1,0,1,3'd2,32'h200,32'h0,       32'h0,   5'd3, 4,32'hDEADBEEF,1,0,1,32'hDEADBEEF,4'h0,32'h0);
        tbl[9]  = mk(0,1,0,3'd1,32'h006,32'h1234ABCD,32'h0,   5'd1, 2,32'h0,       1,0,0,32'h0,       4'hC,32'hABCDABCD);
        tbl[10] = mk(0,1,0,3'd4,32'h000,32'h0,       32'h0,   5'd1, 1,32'h0,       0,1,0,32'h0,       4'h0,32'h0);
        tbl[11] = mk(1,0,1,3'd3,32'h000,32'h0,       32'h0,   5'd1, 1,32'h0,       0,1,0,32'h0,       4'h0,32'h0);
        tbl[12] = mk(0,0,1,3'd0,32'h0,  32'h0,       32'h55,  5'd0, 1,32'h0,       0,0,0,32'h55,      4'h0,32'h0);
        tbl[13] = mk(1,1,1,3'd0,32'h001,32'h0,       32'h0,   5'd4, 1,32'h00007F00,1,0,1,32'h0000007F,4'h0,32'h0);
        tbl[14] = mk(0,1,0,3'd2,32'h010,32'hCAFEF00D,32'h0,   5'd1, 1,32'h0,       1,0,0,32'h0,       4'hF,32'hCAFEF00D);
        tbl[15] = mk(1,0,1,3'd5,32'h002,32'h0,       32'h0,   5'd6, 3,32'h80F01234,1,0,1,32'h000080F0,4'h0,32'h0);
        tbl[16] = mk(0,1,0,3'd2,32'h020,32'h11223344,32'h0,   5'd1, 6,32'h0,       1,1,0,32'h0,       4'hF,32'h11223344);
        tbl[17] = mk(1,0,1,3'd1,32'h101,32'h0,       32'h0,   5'd1, 1,32'h0,       0,1,0,32'h0,       4'h0,32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_dmem_req", dmem_req, 1'b0);
        chk32("rst_wb_data", wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("post_rst_ready", in_ready, 1'b1);

        // Three back-to-back ALU ops
        @(negedge clk);
        in_valid = 1'b1; load = 1'b0; store = 1'b0; we_reg = 1'b1;
        rd_in = 5'd5; wd_reg = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("b2b_wb_valid", wb_valid, 1'b1);
            chk1("b2b_wb_we", wb_we, 1'b1);
            chk32("b2b_wb_data", wb_data, 32'h1234);
            chk1("b2b_in_ready", in_ready, 1'b1);
            $display("txn b2b %0d: wb_valid=%b wb_data=0x%08h", i, wb_valid, wb_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk1("b2b_pulse_end", wb_valid, 1'b0);

        foreach (tbl[i]) run_instr(tbl[i], i);

        // Reset during ACCESS discards the transaction
        @(negedge clk);
        in_valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'd2;
        ls_mem_addr = 32'h40; rd_in = 5'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("mid_rst_req_up", dmem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("mid_rst_req_async", dmem_req, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("mid_rst_no_wb", wb_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("after_rst_ready", in_ready, 1'b1);
        chk1("after_rst_no_wb", wb_valid, 1'b0);
        $display("txn reset_mid_access: dmem_req=%b in_ready=%b", dmem_req, in_ready);
        run_instr(mk(1,0,1,3'd2,32'h44,32'h0,32'h0,5'd12,2,32'h13572468,
                     1,0,1,32'h13572468,4'h0,32'h0), 100);

        // Randomized instructions against the model
        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            rv = '0;
            rv.load   = (kind == 1) || (kind == 3);
            rv.store  = (kind == 2) || (kind == 3);
            rv.we_reg = 1'($urandom_range(0, 1));
            rv.f3     = 3'($urandom_range(0, 7));
            rv.addr   = $urandom;
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.wd_mem = $urandom;
            rv.wd_reg = $urandom;
            rv.rd     = 5'($urandom_range(0, 31));
            rv.dly    = $urandom_range(1, MAXW + 2);
            rv.rdata  = $urandom;
            rv.e      = model(rv);
            run_instr(rv, 200 + i);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access/writeback stage directly downstream of the ALU controller.
- Takes one executed instruction per handshake: store/load flags, address, store data, register write data, rd.
- Performs byte/half/word accesses on a single-outstanding data-memory bus with a wait-state timeout.
- Emits a one-cycle registered writeback to the register file: load data is lane-extracted and sign/zero-extended.

Parameters:
- MAX_WAIT, 16: number of ACCESS cycles without dmem_ack before a bus error is declared (≥1).

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; asynchronous, active-high
- in_valid  in  1  execute-stage result valid
- in_ready  out  1  stage can accept an instruction this cycle
- store  in  1  instruction is a store
- load  in  1  instruction is a load
- we_reg  in  1  instruction writes rd
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ls_mem_addr  in  32  byte address for load/store
- wd_mem  in  32  store data (low bits significant)
- wd_reg  in  32  non-load writeback value
- rd_in  in  5  destination register
- dmem_req  out  1  memory request; held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (ls_mem_addr with [1:0] = 0)
- dmem_wdata  out  32  store data replicated into lanes
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  request completed; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  writeback pulse (one cycle)
- wb_we  out  1  write rd
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- wb_err  out  1  misaligned, illegal funct3 or bus timeout

Behaviour:
- Reset: state IDLE; wait counter 0; all outputs 0 except in_ready = 0 while RST is high.
  - RST asserted mid-ACCESS drops dmem_req asynchronously; the transaction is discarded with no writeback.
- States: IDLE, ACCESS. in_ready = (state == IDLE) && !RST. Accept = in_valid && in_ready.
- Accept, neither load nor store:
  - Next cycle: wb_valid = 1, wb_data = wd_reg, wb_rd = rd_in, wb_we = we_reg && rd_in != 0.
  - State stays IDLE, giving throughput of 1 per cycle.
- Accept, load or store (load wins if both set):
  - Fault check first: misaligned (H with addr[0] = 1; W with addr[1:0] != 0) or illegal funct3 (store: not 000/001/010; load: 011, 110, 111).
  - On fault: no bus request; next cycle wb_valid = 1, wb_err = 1, wb_we = 0, wb_data = 0; remain IDLE.
  - Otherwise: latch the fields and go to ACCESS. dmem_req rises the cycle after accept, registered.
- Store lanes:
  - SB: wdata = {4{wd_mem[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{wd_mem[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000, dmem_we = 0.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable until the ack.
  - The wait counter increments each ACCESS cycle without an ack.
- dmem_ack seen in ACCESS: dmem_req = 0 next cycle and the state returns to IDLE. Next cycle: wb_valid = 1, wb_err = 0.
  - Load: wb_data = extracted byte/half at addr[1:0], sign-extended (B, H) or zero-extended (BU, HU). wb_we = (rd != 0).
  - Store: wb_we = 0, wb_data = 0.
- Timeout: counter reaches MAX_WAIT with no ack → drop req; wb_valid = 1, wb_err = 1, wb_we = 0; go to IDLE.
  - An ack in the same cycle as the timeout wins and completes normally.
- dmem_ack outside ACCESS is ignored.
- Instruction latency: 1 cycle for non-memory ops and faults; (ack cycle + 1) for memory ops.
- wb_* outputs are valid only while wb_valid = 1. wb_valid is 0 on every cycle with no completion.

Test Plan:
- ALU op with rd = 5, wd_reg = 0x1234 on three back-to-back cycles → three consecutive wb_valid pulses, each wb_we = 1, wb_data = 0x1234. in_ready stays 1 throughout.
- SB to addr 0x103 with wd_mem = 0xAB → dmem_wdata = 0xABABABAB, wstrb = 1000, dmem_addr = 0x100. Ack after 3 cycles → wb_valid one cycle later with wb_we = 0.
- LB, LBU and LH at addr 0x102 with dmem_rdata = 0x80F0_1234:
  - LB → wb_data = 0xFFFFFFF0.
  - LBU → wb_data = 0x000000F0.
  - LH → wb_data = 0xFFFF80F0.
- LW at addr 0x002 → no dmem_req; next cycle wb_err = 1, wb_we = 0. LH to rd = 0 with a normal ack → wb_we = 0.
- MAX_WAIT = 4 with no ack → req drops after 4 ACCESS cycles, wb_err = 1. Repeat with the ack in the 4th cycle → normal completion, wb_err = 0.
- Assert RST during ACCESS → dmem_req falls without waiting for a clock edge; no wb_valid. After RST is released, in_ready = 1 and a fresh LW completes normally.
